load_sequencer: RTL and testbench
=================================

Name: load_sequencer

Overview:
- Layer-level load scheduler that sequences the kernel, bias and input-feature SRAM store engines for one convolution layer.
- Loads kernel, then bias, then walks the row tiles (TOP / MID / BOTT). Each input-feature tile load is released only after compute has consumed the previous tile.
- Sits between the master FSM and the store engines. It issues one-cycle start pulses and reports tile and layer completion.

Parameters:
- TILE_W, 6, width of tile count and tile index (max 2^TILE_W-1 tiles)
- POS_W, 2, width of tile position code (shared package value)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- seq_start  in  1  one-cycle request to begin a layer load; sampled only in IDLE
- cfg_num_tiles  in  TILE_W  number of row tiles; latched on accepted seq_start; 0 is treated as 1
- ker_store_busy  in  1  kernel store engine busy
- ker_store_done  in  1  kernel store engine finished (one-cycle pulse)
- bias_store_busy  in  1  bias store engine busy
- bias_store_done  in  1  bias store engine finished (pulse)
- if_store_busy  in  1  input-feature store engine busy
- if_store_done  in  1  input-feature store engine finished (pulse)
- compute_done  in  1  compute has consumed the current tile (pulse)
- start_ker_store  out  1  registered start pulse to kernel store
- start_bias_store  out  1  registered start pulse to bias store
- start_if_store  out  1  registered start pulse to input-feature store
- tile_idx  out  TILE_W  index of the tile being loaded or computed
- tile_pos  out  POS_W  0=NONE, 1=TOP, 2=MID, 3=BOTT
- tile_ready  out  1  pulse: current tile is in SRAM and compute may start
- seq_done  out  1  pulse: whole layer has been loaded and consumed
- seq_busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset: all outputs are 0, state is IDLE, and the issued flag and latched tile count are cleared. A reset asserted mid-operation aborts immediately, with no done pulse.
- States: IDLE, KER, BIAS, IF, WAIT_CMP, DONE.
- IDLE to KER: on seq_start, latching cfg_num_tiles (0 becomes 1) and setting tile_idx=0. seq_start in any other state is ignored.
- Start pulses (KER, BIAS and IF states):
  - On each state entry the issued flag is cleared.
  - On the first cycle with issued=0, busy=0 and done=0, the matching start_* is driven to 1 for exactly one cycle (registered output) and issued is set.
  - Earliest pulse is the cycle after entry. If busy at entry, the pulse waits until busy falls.
  - At most one pulse per state entry.
- Completion of a load state:
  - The engine's done is honoured only when issued=1. A done while issued=0 is ignored.
  - KER to BIAS on ker_store_done.
  - BIAS to IF on bias_store_done.
  - IF to WAIT_CMP on if_store_done, with tile_ready=1 on the transition cycle (registered, visible the cycle after done).
- WAIT_CMP:
  - compute_done is sampled only in this state; a compute_done outside WAIT_CMP is dropped.
  - On compute_done with tile_idx==num_tiles-1, go to DONE.
  - Otherwise increment tile_idx and return to IF.
- DONE: seq_done=1 for one cycle, then IDLE the next cycle.
- tile_pos: NONE in IDLE, KER and BIAS. Otherwise tile_idx==0 gives TOP, tile_idx==num_tiles-1 with num_tiles>1 gives BOTT, and anything else gives MID. With num_tiles==1 the single tile is TOP.
- tile_idx holds its value through DONE and clears on the next accepted seq_start.
- Simultaneous busy and done on the same cycle: done wins and no start pulse is issued.

Optional Feature:
- Macro: LDSEQ_BIAS_EN.
- Defined: BIAS state present as described.
- Undefined:
  - BIAS state is removed; KER goes directly to IF on ker_store_done.
  - start_bias_store is tied to 0.
  - bias_store_busy and bias_store_done are unused.

Decomposition:
- Shared package holds:
  - the state encodings (3-bit: IDLE=0, KER=1, BIAS=2, IF=3, WAIT_CMP=4, DONE=7);
  - the tile_pos codes (NONE, TOP, MID, BOTT);
  - POS_W.
- One natural sub-module: ldseq_start_gen. It implements one issued flag and the start-pulse rule, taking the state-entry, busy and done inputs, and is instantiated three times.

Test Plan:
- num_tiles=3, engines never busy, each done 5 cycles after its start, compute_done 4 cycles after each tile_ready. Required: exactly one start_ker, one start_bias and three start_if pulses; tile_pos TOP, MID, BOTT; three tile_ready pulses; one seq_done; back to IDLE.
- ker_store_busy held high for 10 cycles after entering KER. Required: start_ker_store fires exactly on the cycle after busy falls, and never while busy=1.
- num_tiles=0 (and separately 1). Required: one IF load only, tile_pos=TOP, seq_done after the first compute_done.
- Spurious ker_store_done before start_ker_store, plus compute_done during IF. Required: no state change; sequence completes normally.
- reset asserted in WAIT_CMP of tile 1 of 4. Required: next cycle all outputs are 0 and state is IDLE; a new seq_start runs a full sequence cleanly.
- With LDSEQ_BIAS_EN undefined. Required: the sequence runs KER then IF, and start_bias_store stays 0 throughout.

Source files
------------

// File: rtl/load_sequencer_pkg.sv
// Shared encodings for the load_sequencer slice: FSM states, tile position codes
// and the position code width.
package load_sequencer_pkg;

  localparam int POS_W = 2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_KER      = 3'd1,
    S_BIAS     = 3'd2,
    S_IF       = 3'd3,
    S_WAIT_CMP = 3'd4,
    S_DONE     = 3'd7
  } state_t;

  typedef enum logic [POS_W-1:0] {
    POS_NONE = 2'd0,
    POS_TOP  = 2'd1,
    POS_MID  = 2'd2,
    POS_BOTT = 2'd3
  } tile_pos_t;

endpackage

// File: rtl/load_sequencer_if.sv
// Control bundle between the master FSM / store engines / compute and the
// load_sequencer. The master modport is the sequencer's view.
interface load_sequencer_if #(
  parameter int TILE_W = 6
);
  import load_sequencer_pkg::*;

  logic              seq_start;
  logic [TILE_W-1:0] cfg_num_tiles;
  logic              ker_store_busy;
  logic              ker_store_done;
  logic              bias_store_busy;
  logic              bias_store_done;
  logic              if_store_busy;
  logic              if_store_done;
  logic              compute_done;
  logic              start_ker_store;
  logic              start_bias_store;
  logic              start_if_store;
  logic [TILE_W-1:0] tile_idx;
  logic [POS_W-1:0]  tile_pos;
  logic              tile_ready;
  logic              seq_done;
  logic              seq_busy;

  modport master (
    input  seq_start, cfg_num_tiles,
    input  ker_store_busy, ker_store_done,
    input  bias_store_busy, bias_store_done,
    input  if_store_busy, if_store_done,
    input  compute_done,
    output start_ker_store, start_bias_store, start_if_store,
    output tile_idx, tile_pos, tile_ready, seq_done, seq_busy
  );

  modport slave (
    output seq_start, cfg_num_tiles,
    output ker_store_busy, ker_store_done,
    output bias_store_busy, bias_store_done,
    output if_store_busy, if_store_done,
    output compute_done,
    input  start_ker_store, start_bias_store, start_if_store,
    input  tile_idx, tile_pos, tile_ready, seq_done, seq_busy
  );

endinterface

// File: rtl/ldseq_start_gen.sv
// One store-engine start pulse generator: a single registered pulse per visit
// of the owning state, issued once the engine is neither busy nor reporting done.
module ldseq_start_gen (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic busy,
  input  logic done,
  output logic start,
  output logic issued
);

  logic start_r;
  logic issued_r;

  // issued is held clear while the owning state is not current, so each entry starts fresh
  always_ff @(posedge clk) begin
    if (reset) begin
      start_r  <= 1'b0;
      issued_r <= 1'b0;
    end else if (!active) begin
      start_r  <= 1'b0;
      issued_r <= 1'b0;
    end else if (!issued_r && !busy && !done) begin
      start_r  <= 1'b1;
      issued_r <= 1'b1;
    end else begin
      start_r  <= 1'b0;
    end
  end

  assign start  = start_r;
  assign issued = issued_r;

endmodule

// File: rtl/load_sequencer.sv
// Layer load scheduler: kernel, optional bias (LDSEQ_BIAS_EN), then per-tile
// input-feature loads, each released only after compute consumed the previous tile.
module load_sequencer
  import load_sequencer_pkg::*;
#(
  parameter int TILE_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  load_sequencer_if.master  bus
);

  state_t            state_r;
  logic [TILE_W-1:0] num_tiles_r;
  logic [TILE_W-1:0] tile_idx_r;
  logic              tile_ready_r;
  logic              seq_done_r;
  logic              last_tile;
  logic              ker_issued;
  logic              if_issued;
  logic              start_ker;
  logic              start_bias;
  logic              start_if;
  tile_pos_t         pos;

  assign last_tile = (tile_idx_r == (num_tiles_r - TILE_W'(1)));

  ldseq_start_gen u_ker_start (
    .clk    (clk),
    .reset  (reset),
    .active (state_r == S_KER),
    .busy   (bus.ker_store_busy),
    .done   (bus.ker_store_done),
    .start  (start_ker),
    .issued (ker_issued)
  );

`ifdef LDSEQ_BIAS_EN
  logic bias_issued;

  ldseq_start_gen u_bias_start (
    .clk    (clk),
    .reset  (reset),
    .active (state_r == S_BIAS),
    .busy   (bus.bias_store_busy),
    .done   (bus.bias_store_done),
    .start  (start_bias),
    .issued (bias_issued)
  );
`else
  assign start_bias = 1'b0;
`endif

  ldseq_start_gen u_if_start (
    .clk    (clk),
    .reset  (reset),
    .active (state_r == S_IF),
    .busy   (bus.if_store_busy),
    .done   (bus.if_store_done),
    .start  (start_if),
    .issued (if_issued)
  );

  // Layer sequencing FSM; engine done pulses only count after that state's start was issued
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_IDLE;
      num_tiles_r  <= {TILE_W{1'b0}};
      tile_idx_r   <= {TILE_W{1'b0}};
      tile_ready_r <= 1'b0;
      seq_done_r   <= 1'b0;
    end else begin
      tile_ready_r <= 1'b0;
      seq_done_r   <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (bus.seq_start) begin
            num_tiles_r <= (bus.cfg_num_tiles == {TILE_W{1'b0}}) ? TILE_W'(1) : bus.cfg_num_tiles;
            tile_idx_r  <= {TILE_W{1'b0}};
            state_r     <= S_KER;
          end
        end
        S_KER: begin
          if (bus.ker_store_done && ker_issued) begin
`ifdef LDSEQ_BIAS_EN
            state_r <= S_BIAS;
`else
            state_r <= S_IF;
`endif
          end
        end
`ifdef LDSEQ_BIAS_EN
        S_BIAS: begin
          if (bus.bias_store_done && bias_issued) begin
            state_r <= S_IF;
          end
        end
`endif
        S_IF: begin
          if (bus.if_store_done && if_issued) begin
            tile_ready_r <= 1'b1;
            state_r      <= S_WAIT_CMP;
          end
        end
        S_WAIT_CMP: begin
          if (bus.compute_done) begin
            if (last_tile) begin
              seq_done_r <= 1'b1;
              state_r    <= S_DONE;
            end else begin
              tile_idx_r <= tile_idx_r + TILE_W'(1);
              state_r    <= S_IF;
            end
          end
        end
        S_DONE:  state_r <= S_IDLE;
        default: state_r <= S_IDLE;
      endcase
    end
  end

  // Tile position derived from the registered index; a single tile reports TOP
  always_comb begin
    pos = POS_NONE;
    case (state_r)
      S_IF, S_WAIT_CMP, S_DONE: begin
        if (tile_idx_r == {TILE_W{1'b0}}) begin
          pos = POS_TOP;
        end else if (last_tile) begin
          pos = POS_BOTT;
        end else begin
          pos = POS_MID;
        end
      end
      default: pos = POS_NONE;
    endcase
  end

  assign bus.start_ker_store  = start_ker;
  assign bus.start_bias_store = start_bias;
  assign bus.start_if_store   = start_if;
  assign bus.tile_idx         = tile_idx_r;
  assign bus.tile_pos         = pos;
  assign bus.tile_ready       = tile_ready_r;
  assign bus.seq_done         = seq_done_r;
  assign bus.seq_busy         = (state_r != S_IDLE);

endmodule

// File: tb/tb_load_sequencer.sv
// Bench for load_sequencer: reactive engine/compute models with random latencies,
// checked against pulse counts, tile positions and start timing derived from the layer rules.
module tb_load_sequencer;

  localparam int TILE_W = 6;
`ifdef LDSEQ_BIAS_EN
  localparam int BIAS_EN = 1;
`else
  localparam int BIAS_EN = 0;
`endif

  logic clk = 1'b0;
  logic reset;

  load_sequencer_if #(.TILE_W(TILE_W)) bus ();

  load_sequencer #(.TILE_W(TILE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int n_ker, n_bias, n_if, n_rdy, n_done, viol;
  int fix_lat = 0;
  int fix_cmp = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: sample 1 time unit after the edge and tally output pulses
  task automatic tick();
    logic kb;
    kb = bus.ker_store_busy;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.start_ker_store) begin
      n_ker++;
      if (kb) viol++;
    end
    if (bus.start_bias_store) n_bias++;
    if (bus.start_if_store)   n_if++;
    if (bus.tile_ready)       n_rdy++;
    if (bus.seq_done)         n_done++;
  endtask

  function automatic int outs();
    return int'({bus.start_ker_store, bus.start_bias_store, bus.start_if_store,
                 bus.tile_ready, bus.seq_done, bus.seq_busy, bus.tile_pos, bus.tile_idx});
  endfunction

  function automatic int exp_pos(input int i, input int n);
    if (i == 0)          return 1;
    else if (i == n - 1) return 3;
    else                 return 2;
  endfunction

  function automatic int lat(input int fix);
    return (fix != 0) ? fix : int'($urandom_range(2, 6));
  endfunction

  task automatic wait_for(input int which, output int at);
    at = 0;
    for (int k = 0; k < 40 && at == 0; k++) begin
      tick();
      case (which)
        1:       if (bus.start_bias_store) at = cyc;
        2:       if (bus.start_if_store)   at = cyc;
        default: if (bus.start_ker_store)  at = cyc;
      endcase
    end
  endtask

  task automatic pulse_done(input int which, output int at);
    case (which)
      1:       bus.bias_store_done = 1'b1;
      2:       bus.if_store_done   = 1'b1;
      3:       bus.compute_done    = 1'b1;
      default: bus.ker_store_done  = 1'b1;
    endcase
    tick();
    at = cyc;
    bus.ker_store_done  = 1'b0;
    bus.bias_store_done = 1'b0;
    bus.if_store_done   = 1'b0;
    bus.compute_done    = 1'b0;
  endtask

  task automatic run_layer(input int n, input int ker_busy, input bit spur, input int abort_tile);
    int  eff, e_start, got, d, l;
    bit  clr;
    eff = (n == 0) ? 1 : n;
    n_ker = 0; n_bias = 0; n_if = 0; n_rdy = 0; n_done = 0; viol = 0;

    bus.cfg_num_tiles = TILE_W'(n);
    bus.seq_start     = 1'b1;
    tick();
    bus.seq_start = 1'b0;
    check_eq("busy_on", int'(bus.seq_busy), 1);
    check_eq("pos_ker", int'(bus.tile_pos), 0);

    // Start is due on the first edge in KER seeing neither busy nor done
    e_start = 0;
    got     = 0;
    for (int k = 1; k <= 40 && got == 0; k++) begin
      bus.ker_store_busy = (k <= ker_busy);
      bus.ker_store_done = spur && (k == 1);
      clr = !bus.ker_store_busy && !bus.ker_store_done;
      tick();
      if (clr && e_start == 0) e_start = cyc;
      if (bus.start_ker_store) got = cyc;
    end
    bus.ker_store_busy = 1'b0;
    bus.ker_store_done = 1'b0;
    check_eq("ker_start_cyc", got, e_start);

    l = lat(fix_lat);
    repeat (l - 1) tick();
    pulse_done(0, d);

    if (BIAS_EN != 0) begin
      wait_for(1, got);
      check_eq("bias_start_cyc", got, d + 1);
      l = lat(fix_lat);
      repeat (l - 1) tick();
      pulse_done(1, d);
    end

    for (int i = 0; i < eff; i++) begin
      wait_for(2, got);
      check_eq("if_start_cyc", got, d + 1);
      l = lat(fix_lat);
      for (int k = 0; k < l - 1; k++) begin
        bus.compute_done = spur && (k == 0);
        tick();
      end
      bus.compute_done = 1'b0;
      pulse_done(2, d);
      check_eq("tile_ready", int'(bus.tile_ready), 1);
      check_eq("tile_pos", int'(bus.tile_pos), exp_pos(i, eff));
      check_eq("tile_idx", int'(bus.tile_idx), i);

      l = lat(fix_cmp);
      repeat (l - 1) tick();
      if (i == abort_tile) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("abort_outs", outs(), 0);
        check_eq("abort_no_done", n_done, 0);
        return;
      end
      pulse_done(3, d);
      if (i == eff - 1) check_eq("seq_done", int'(bus.seq_done), 1);
    end

    tick();
    check_eq("busy_off", int'(bus.seq_busy), 0);
    check_eq("idx_hold", int'(bus.tile_idx), eff - 1);
    check_eq("pos_idle", int'(bus.tile_pos), 0);
    check_eq("n_ker", n_ker, 1);
    check_eq("n_bias", n_bias, BIAS_EN);
    check_eq("n_if", n_if, eff);
    check_eq("n_ready", n_rdy, eff);
    check_eq("n_done", n_done, 1);
    check_eq("ker_start_while_busy", viol, 0);
  endtask

  initial begin
    reset               = 1'b1;
    bus.seq_start       = 1'b0;
    bus.cfg_num_tiles   = '0;
    bus.ker_store_busy  = 1'b0;
    bus.ker_store_done  = 1'b0;
    bus.bias_store_busy = 1'b0;
    bus.bias_store_done = 1'b0;
    bus.if_store_busy   = 1'b0;
    bus.if_store_done   = 1'b0;
    bus.compute_done    = 1'b0;
    repeat (3) tick();
    check_eq("reset_outs", outs(), 0);
    reset = 1'b0;
    tick();
    check_eq("idle_outs", outs(), 0);

    fix_lat = 5;
    fix_cmp = 4;
    run_layer(3, 0, 1'b0, -1);
    fix_lat = 0;
    fix_cmp = 0;
    run_layer(2, 10, 1'b0, -1);
    run_layer(0, 0, 1'b0, -1);
    run_layer(1, 0, 1'b0, -1);
    run_layer(3, 0, 1'b1, -1);
    run_layer(4, 0, 1'b0, 1);
    run_layer(4, 0, 1'b0, -1);
    for (int r = 0; r < 6; r++) begin
      run_layer(int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
                1'($urandom_range(0, 1)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
